// File: rtl/aes_pkg.sv
// Shared AES constants, key-length encoding, forward S-box table and GF(2^8) xtime helper
// for the iterative key expander.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2
  } key_len_e;

  localparam int unsigned NK_128    = 4;
  localparam int unsigned NK_192    = 6;
  localparam int unsigned NK_256    = 8;
  localparam int unsigned NR_128    = 10;
  localparam int unsigned NR_192    = 12;
  localparam int unsigned NR_256    = 14;
  localparam int unsigned MAX_WORDS = 60;
  localparam int unsigned KEY_W     = 256;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned RK_W      = 128;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_key_expander_seq_if.sv
// Request/status/round-key-read bundle between the cipher control and the key expander.
// AES_KEY_ZEROIZE_EN adds the zeroize request line.
interface aes_key_expander_seq_if;
  import aes_pkg::*;

  logic              start;
  logic [1:0]        key_len;
  logic [KEY_W-1:0]  key_in;
  logic              busy;
  logic              done;
  logic              key_valid;
  logic              err;
  logic [3:0]        nr;
  logic [3:0]        rk_idx;
  logic [RK_W-1:0]   rk_out;
`ifdef AES_KEY_ZEROIZE_EN
  logic              zeroize;
`endif

  modport master (
`ifdef AES_KEY_ZEROIZE_EN
    output zeroize,
`endif
    output start, key_len, key_in, rk_idx,
    input  busy, done, key_valid, err, nr, rk_out
  );

  modport slave (
`ifdef AES_KEY_ZEROIZE_EN
    input  zeroize,
`endif
    input  start, key_len, key_in, rk_idx,
    output busy, done, key_valid, err, nr, rk_out
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte per instance.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  assign out_o = sbox_fwd(in_i);

endmodule

// File: rtl/aes_key_expander_seq.sv
// Iterative AES-128/192/256 key expander: one schedule word per clock, indexed round-key read.
// AES_KEY_ZEROIZE_EN adds a zeroize input that wipes the schedule and aborts expansion.
module aes_key_expander_seq #(
  parameter int unsigned MAX_WORDS   = aes_pkg::MAX_WORDS,
  parameter bit          RK_READ_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aes_key_expander_seq_if.slave bus
);
  import aes_pkg::*;

  localparam int unsigned IDX_W = $clog2(MAX_WORDS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [2:0]        mod_q, mod_d;
  logic [7:0]        rcon_q, rcon_d;
  logic [3:0]        nk_q, nk_d;
  logic [3:0]        nr_run_q, nr_run_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              key_valid_q, key_valid_d;
  logic [3:0]        nr_q, nr_d;

  logic [WORD_W-1:0] w_q [MAX_WORDS];

  logic              legal_c;
  logic [3:0]        nk_sel_c;
  logic [3:0]        nr_sel_c;
  logic              load_c;
  logic              wr_c;
  logic [WORD_W-1:0] t_c;
  logic [WORD_W-1:0] prev_c;
  logic [WORD_W-1:0] sub_in_c;
  logic [WORD_W-1:0] sub_out_c;
  logic [WORD_W-1:0] new_word_c;
  logic              first_c;
  logic              mid_c;

  // Key-length decode
  always_comb begin
    legal_c  = 1'b1;
    nk_sel_c = 4'(NK_128);
    nr_sel_c = 4'(NR_128);
    case (bus.key_len)
      KL_128: begin nk_sel_c = 4'(NK_128); nr_sel_c = 4'(NR_128); end
      KL_192: begin nk_sel_c = 4'(NK_192); nr_sel_c = 4'(NR_192); end
      KL_256: begin nk_sel_c = 4'(NK_256); nr_sel_c = 4'(NR_256); end
      default: legal_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    last_d      = last_q;
    mod_d       = mod_q;
    rcon_d      = rcon_q;
    nk_d        = nk_q;
    nr_run_d    = nr_run_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    key_valid_d = key_valid_q;
    nr_d        = nr_q;
    load_c      = 1'b0;
    wr_c        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (legal_c) begin
            load_c      = 1'b1;
            nk_d        = nk_sel_c;
            nr_run_d    = nr_sel_c;
            last_d      = IDX_W'({nr_sel_c, 2'b11});
            i_d         = IDX_W'(nk_sel_c);
            mod_d       = 3'd0;
            rcon_d      = 8'h01;
            busy_d      = 1'b1;
            key_valid_d = 1'b0;
            state_d     = S_EXPAND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_EXPAND: begin
        wr_c  = 1'b1;
        i_d   = i_q + IDX_W'(1);
        mod_d = (mod_q == 3'(nk_q - 4'd1)) ? 3'd0 : mod_q + 3'd1;
        if (first_c) rcon_d = xtime(rcon_q);
        if (i_q == last_q) begin
          busy_d      = 1'b0;
          done_d      = 1'b1;
          key_valid_d = 1'b1;
          nr_d        = nr_run_q;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef AES_KEY_ZEROIZE_EN
    // Zeroize wins over everything, including a same-cycle start
    if (bus.zeroize) begin
      state_d     = S_IDLE;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      key_valid_d = 1'b0;
      nr_d        = 4'd0;
      load_c      = 1'b0;
      wr_c        = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      last_q      <= '0;
      mod_q       <= '0;
      rcon_q      <= '0;
      nk_q        <= '0;
      nr_run_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      key_valid_q <= 1'b0;
      nr_q        <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      last_q      <= last_d;
      mod_q       <= mod_d;
      rcon_q      <= rcon_d;
      nk_q        <= nk_d;
      nr_run_q    <= nr_run_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      key_valid_q <= key_valid_d;
      nr_q        <= nr_d;
    end
  end

  // Schedule word datapath: single SubWord path shared by RotWord and the Nk=8 mid-key rule
  assign t_c        = w_q[i_q - IDX_W'(1)];
  assign prev_c     = w_q[i_q - IDX_W'(nk_q)];
  assign first_c    = (mod_q == 3'd0);
  assign mid_c      = (nk_q == 4'(NK_256)) && (mod_q == 3'd4);
  assign sub_in_c   = first_c ? {t_c[23:0], t_c[31:24]} : t_c;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (sub_in_c[8*g +: 8]),
      .out_o (sub_out_c[8*g +: 8])
    );
  end

  always_comb begin
    new_word_c = prev_c ^ t_c;
    if (first_c)    new_word_c = prev_c ^ sub_out_c ^ {rcon_q, 24'h0};
    else if (mid_c) new_word_c = prev_c ^ sub_out_c;
  end

  // Storage has no reset; key_valid gates every read
  always_ff @(posedge clk) begin
`ifdef AES_KEY_ZEROIZE_EN
    if (bus.zeroize) begin
      for (int k = 0; k < int'(MAX_WORDS); k++) w_q[k] <= '0;
    end else
`endif
    if (load_c) begin
      for (int k = 0; k < int'(NK_256); k++) w_q[k] <= bus.key_in[KEY_W-1-WORD_W*k -: WORD_W];
    end else if (wr_c) begin
      w_q[i_q] <= new_word_c;
    end
  end

  logic [IDX_W-1:0] rd_base_c;
  logic             rd_ok_c;
  logic [RK_W-1:0]  rk_c;

  assign rd_base_c = IDX_W'({bus.rk_idx, 2'b00});
  assign rd_ok_c   = key_valid_q && (bus.rk_idx <= nr_q);
  assign rk_c      = rd_ok_c ? {w_q[rd_base_c], w_q[rd_base_c + IDX_W'(1)],
                                w_q[rd_base_c + IDX_W'(2)], w_q[rd_base_c + IDX_W'(3)]} : '0;

  if (RK_READ_REG) begin : g_rk_reg
    logic [RK_W-1:0] rk_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rk_q <= '0;
      end else begin
`ifdef AES_KEY_ZEROIZE_EN
        rk_q <= bus.zeroize ? '0 : rk_c;
`else
        rk_q <= rk_c;
`endif
      end
    end
    assign bus.rk_out = rk_q;
  end else begin : g_rk_comb
    assign bus.rk_out = rk_c;
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.key_valid = key_valid_q;
  assign bus.nr        = nr_q;

endmodule

// File: doc/aes_key_expander_seq.md
Name: aes_key_expander_seq

Overview:
Iterative AES key expansion supporting all three key lengths: AES-128, AES-192 and AES-256. It computes one 32-bit schedule word per clock and stores the full schedule in an internal register array. The cipher datapath reads round keys by index through a registered read port. It replaces the fully unrolled combinational 128-bit expander; logic area drops to one SubWord path (4 S-boxes) plus storage, and the block gains key-length mode and a start/done handshake.

Parameters:
MAX_WORDS, 60, schedule storage depth in 32-bit words (covers AES-256; 4*(14+1))
RK_READ_REG, 1, 1 = registered round-key read (1-cycle latency); 0 = combinational read

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to expand key_in using key_len
key_len  in  2  0 = 128-bit, 1 = 192-bit, 2 = 256-bit, 3 = illegal
key_in  in  256  key, MSB-first; w0 = key_in[255:224]; unused low bits ignored
busy  out  1  expansion in progress
done  out  1  one-cycle pulse when the last word has been written
key_valid  out  1  schedule complete and consistent with last accepted key
err  out  1  one-cycle pulse when start arrives with key_len = 3
nr  out  4  round count of stored schedule: 10, 12 or 14
rk_idx  in  4  round-key index 0..nr
rk_out  out  128  round key rk_idx = {w[4k], w[4k+1], w[4k+2], w[4k+3]}

Behaviour:
- Reset (async, rst_n low): FSM to IDLE; busy=0, done=0, err=0, key_valid=0, nr=0, rk_out=0. Storage contents are don't-care but rk_out reads 0 while key_valid=0.
- Nk/Nr/total words: 4/10/44, 6/12/52, 8/14/60.
- FSM states:
  - IDLE: on start with a legal key_len, load w[0..Nk-1] from key_in, latch Nk/Nr, set i=Nk, rcon=0x01, busy=1, key_valid=0, and go to EXPAND. start with key_len=3 gives err=1 for one cycle and no other change; the previous schedule and key_valid are kept.
  - EXPAND: one word per cycle, t = w[i-1]:
    - i mod Nk == 0: w[i] = w[i-Nk] ^ SubWord(RotWord(t)) ^ {rcon,24'h0}; then rcon = xtime(rcon), i.e. (rcon<<1) ^ (rcon[7] ? 0x1B : 0).
    - Nk == 8 and i mod 8 == 4: w[i] = w[i-8] ^ SubWord(t).
    - Otherwise: w[i] = w[i-Nk] ^ t.
    - i increments each cycle. After writing w[total-1], go to DONE.
  - DONE (one cycle): done=1, busy=0, key_valid=1, nr updated; go to IDLE.
- Latency from start to done: 41 cycles (AES-128), 47 (AES-192), 53 (AES-256).
- start while busy is ignored; no err, no restart.
- i mod Nk is tracked with a wrapping counter (0..Nk-1), not a divider.
- Read port:
  - rk_out = round key rk_idx, one cycle after rk_idx is presented when RK_READ_REG=1.
  - rk_idx > nr, or key_valid=0, gives rk_out = 0.
- Reads during EXPAND return 0; key_valid stays low until DONE.

Optional Feature:
AES_KEY_ZEROIZE_EN:
- When defined, adds input port zeroize (1 bit).
- A zeroize pulse, in any state, clears every storage word, rk_out, nr and key_valid to 0 on the next edge, aborts any expansion, and returns the FSM to IDLE. done is not pulsed.
- Zeroize has priority over a simultaneous start; the start is dropped.
- Without the macro, the port is absent and storage is overwritten only by a new expansion.

Decomposition:
- Package aes_pkg holds:
  - key_len_e enum (KL_128, KL_192, KL_256)
  - constants NK_*, NR_*, MAX_WORDS
  - function xtime
  - function sbox_fwd (256-entry table)
- Sub-module aes_sbox: one byte in, one byte out, combinational; instantiated 4 times for SubWord.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> done 41 cycles after start; rk 1 = a0fafe1788542cb123a339392a6c7605; rk 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; nr=10.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 47 cycles; rk 12 = e98ba06f448c773c8ecc720401002202; nr=12.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 53 cycles; rk 14 = fe4890d1e6188d0b046df344706c631e (exercises the i mod 8 == 4 SubWord rule).
- After the AES-128 run, start with key_len=3 -> err pulses once; key_valid stays 1; rk 10 unchanged. start asserted during busy -> ignored; done timing unchanged.
- rk_idx=11 with nr=10 -> rk_out=0. rst_n low mid-EXPAND -> busy=0 and key_valid=0 immediately; a new start then completes normally.
- With AES_KEY_ZEROIZE_EN: zeroize at cycle 20 of an AES-256 run -> busy=0, no done, rk_out=0 for every index; zeroize and start in the same cycle -> start dropped.
